// File: rtl/memory_access_arbiter.sv
// memory_access_arbiter
//   Shares one memory_manager-wrapped SRAM between the SPI port (single-word
//   write / readback) and the core controller (req/grant, gated chip-select).
//   Bounded SPI streaks and bounded core holds keep either side from starving.
//   Optional feature: define MEM_ARB_STALL_COUNTER_EN to add the
//   core_stall_cycles output (cycles the core waited without a grant).
module memory_access_arbiter #(
  parameter int START_ADDRESS_BIT_WIDTH = 14,
  parameter int MESSAGE_BIT_WIDTH       = 32,
  parameter int READ_LATENCY            = 1,
  parameter int MAX_SPI_STREAK          = 4,
  parameter int MAX_CORE_HOLD           = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               spi_write_req,
  input  logic                               spi_read_req,
  input  logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address,
  input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in,
  output logic                               spi_ack,
  output logic [MESSAGE_BIT_WIDTH-1:0]       spi_rdata,
  output logic                               spi_busy,
  output logic                               spi_overrun,
  input  logic                               spi_overrun_clear,
  output logic                               program_memory_new,
  output logic                               read_memory_sync,
  output logic [START_ADDRESS_BIT_WIDTH-1:0] mm_spi_address,
  output logic [MESSAGE_BIT_WIDTH-1:0]       mm_spi_data_in,
  input  logic [MESSAGE_BIT_WIDTH-1:0]       mm_spi_data_out,
`ifdef MEM_ARB_STALL_COUNTER_EN
  output logic [31:0]                        core_stall_cycles,
`endif
  input  logic                               core_req,
  output logic                               core_grant,
  input  logic                               core_chip_select,
  output logic                               control_chip_select
);

  localparam int STREAK_W = $clog2(MAX_SPI_STREAK + 1);
  localparam int HOLD_W   = $clog2(MAX_CORE_HOLD + 1);
  localparam int LAT_W    = 2;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_SPI_STREAK);
  localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(MAX_CORE_HOLD - 1);
  localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(READ_LATENCY - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $fatal(1, "memory_access_arbiter: READ_LATENCY must be 1..3");
  end

  typedef enum logic [2:0] {IDLE, SPI_WR, SPI_RD, SPI_RD_WAIT, CORE} state_t;

  state_t                               state_q, state_d;
  logic [STREAK_W-1:0]                  streak_q, streak_d;
  logic [HOLD_W-1:0]                    hold_q, hold_d;
  logic [LAT_W-1:0]                     lat_cnt_q, lat_cnt_d;
  logic                                 pending_q, pending_d;
  logic                                 is_write_q, is_write_d;
  logic [START_ADDRESS_BIT_WIDTH-1:0]   addr_q, addr_d;
  logic [MESSAGE_BIT_WIDTH-1:0]         data_q, data_d;
  logic [MESSAGE_BIT_WIDTH-1:0]         rdata_q, rdata_d;
  logic                                 overrun_q, overrun_d;
  logic                                 prog_q, prog_d;
  logic                                 rsync_q, rsync_d;
  logic                                 ack_q, ack_d;
  logic                                 grant_q, grant_d;
  logic                                 read_done;
  logic                                 busy;
`ifdef MEM_ARB_STALL_COUNTER_EN
  logic [31:0]                          stall_q, stall_d;
`endif

  // A write acks in the same cycle it is issued, so the port frees up during
  // that ack cycle; this lets back-to-back writes keep the streak going.
  assign busy = pending_q & ~ack_q;

  // Next-state logic: arbitration FSM, request latch, overrun flag.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d    = state_q;
    streak_d   = streak_q;
    hold_d     = hold_q;
    lat_cnt_d  = lat_cnt_q;
    pending_d  = pending_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    overrun_d  = overrun_q;
    read_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!core_req) streak_d = '0;
        if (pending_q && (!core_req || streak_q < STREAK_MAX)) begin
          state_d = is_write_q ? SPI_WR : SPI_RD;
          if (core_req) streak_d = streak_q + 1'b1;
        end else if (core_req) begin
          state_d  = CORE;
          streak_d = '0;
          hold_d   = '0;
        end
      end
      SPI_WR: begin
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      SPI_RD: begin
        lat_cnt_d = LAT_INIT;
        state_d   = SPI_RD_WAIT;
      end
      SPI_RD_WAIT: begin
        if (lat_cnt_q == '0) begin
          rdata_d   = mm_spi_data_out;
          pending_d = 1'b0;
          read_done = 1'b1;
          state_d   = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      CORE: begin
        if (!core_req || hold_q == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (pending_q) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request latch; a set in the same cycle as a clear leaves overrun high.
    if (spi_overrun_clear) overrun_d = 1'b0;
    if (spi_write_req || spi_read_req) begin
      if (busy) begin
        overrun_d = 1'b1;
      end else begin
        pending_d  = 1'b1;
        is_write_d = spi_write_req;
        addr_d     = spi_address;
        if (spi_write_req) data_d = spi_data_in;
        if (spi_write_req && spi_read_req) overrun_d = 1'b1;
      end
    end

    // Registered Moore outputs decoded from the next state.
    prog_d  = (state_d == SPI_WR);
    rsync_d = (state_d == SPI_RD);
    grant_d = (state_d == CORE);
    ack_d   = (state_d == SPI_WR) | read_done;

`ifdef MEM_ARB_STALL_COUNTER_EN
    stall_d = stall_q;
    if (spi_overrun_clear) stall_d = '0;
    else if (core_req && !grant_q && stall_q != '1) stall_d = stall_q + 1'b1;
`endif
  end

  // State, held request and registered outputs; reset abandons any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      hold_q     <= '0;
      lat_cnt_q  <= '0;
      pending_q  <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      overrun_q  <= 1'b0;
      prog_q     <= 1'b0;
      rsync_q    <= 1'b0;
      ack_q      <= 1'b0;
      grant_q    <= 1'b0;
`ifdef MEM_ARB_STALL_COUNTER_EN
      stall_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      streak_q   <= streak_d;
      hold_q     <= hold_d;
      lat_cnt_q  <= lat_cnt_d;
      pending_q  <= pending_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      overrun_q  <= overrun_d;
      prog_q     <= prog_d;
      rsync_q    <= rsync_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
`ifdef MEM_ARB_STALL_COUNTER_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign spi_ack             = ack_q;
  assign spi_rdata           = rdata_q;
  assign spi_busy            = busy;
  assign spi_overrun         = overrun_q;
  assign program_memory_new  = prog_q;
  assign read_memory_sync    = rsync_q;
  assign mm_spi_address      = addr_q;
  assign mm_spi_data_in      = data_q;
  assign core_grant          = grant_q;
  assign control_chip_select = core_chip_select & grant_q;
`ifdef MEM_ARB_STALL_COUNTER_EN
  assign core_stall_cycles   = stall_q;
`endif

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Self-checking bench for memory_access_arbiter: scoreboard of SPI ops plus an
// SRAM model with READ_LATENCY, timing checks on strobes, acks and grants.
module tb_memory_access_arbiter;

  localparam int SAW = 14;
  localparam int MBW = 32;
  localparam int RL  = 2;

  localparam int SEL_ACK = 0, SEL_RMS = 1, SEL_GRANT = 2, SEL_NOGRANT = 3, SEL_IDLE = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           spi_write_req, spi_read_req, spi_overrun_clear;
  logic [SAW-1:0] spi_address;
  logic [MBW-1:0] spi_data_in;
  logic           spi_ack, spi_busy, spi_overrun;
  logic [MBW-1:0] spi_rdata;
  logic           program_memory_new, read_memory_sync;
  logic [SAW-1:0] mm_spi_address;
  logic [MBW-1:0] mm_spi_data_in;
  logic [MBW-1:0] mm_spi_data_out = '0;
  logic           core_req, core_grant, core_chip_select, control_chip_select;
`ifdef MEM_ARB_STALL_COUNTER_EN
  logic [31:0]    core_stall_cycles;
`endif

  always #5 clk = ~clk;

  memory_access_arbiter #(
    .START_ADDRESS_BIT_WIDTH(SAW), .MESSAGE_BIT_WIDTH(MBW), .READ_LATENCY(RL),
    .MAX_SPI_STREAK(4), .MAX_CORE_HOLD(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_write_req(spi_write_req), .spi_read_req(spi_read_req),
    .spi_address(spi_address), .spi_data_in(spi_data_in),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata), .spi_busy(spi_busy),
    .spi_overrun(spi_overrun), .spi_overrun_clear(spi_overrun_clear),
    .program_memory_new(program_memory_new), .read_memory_sync(read_memory_sync),
    .mm_spi_address(mm_spi_address), .mm_spi_data_in(mm_spi_data_in),
    .mm_spi_data_out(mm_spi_data_out),
`ifdef MEM_ARB_STALL_COUNTER_EN
    .core_stall_cycles(core_stall_cycles),
`endif
    .core_req(core_req), .core_grant(core_grant),
    .core_chip_select(core_chip_select), .control_chip_select(control_chip_select)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic           is_write;
    logic [SAW-1:0] addr;
    logic [MBW-1:0] data;
  } op_t;

  op_t            exp_q[$];
  op_t            mon_op;
  logic [MBW-1:0] ref_mem [logic [SAW-1:0]];
  logic [MBW-1:0] sram    [logic [SAW-1:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [MBW-1:0] ref_rd(input logic [SAW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // SRAM model: garbage right after the strobe, real data READ_LATENCY cycles later.
  logic [3:0] rd_pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin : model
      logic [3:0] nxt;
      nxt = {rd_pipe[2:0], read_memory_sync};
      rd_pipe <= nxt;
      if (read_memory_sync) mm_spi_data_out <= 32'hBAD0_BAD0;
      if (nxt[RL-1]) mm_spi_data_out <= sram.exists(mm_spi_address) ? sram[mm_spi_address] : '0;
      if (program_memory_new) sram[mm_spi_address] = mm_spi_data_in;
    end
  end

  // Monitor: scoreboard pops on ack, strobe contents, grant bookkeeping.
  int   pmn_count = 0, ack_count = 0, pmn_at_grant = -1;
  int   excl_viol = 0, cs_viol = 0;
  logic grant_seen = 1'b0;
  logic grant_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((program_memory_new || read_memory_sync) && core_grant) excl_viol++;
      if (control_chip_select !== (core_chip_select & core_grant)) cs_viol++;
      if (program_memory_new) begin
        pmn_count++;
        check("sb_has_op_at_write_strobe", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("write_strobe_kind", exp_q[0].is_write, 1'b1);
          check("mm_spi_address_wr", mm_spi_address, exp_q[0].addr);
          check("mm_spi_data_in", mm_spi_data_in, exp_q[0].data);
        end
      end
      if (read_memory_sync) begin
        check("sb_has_op_at_read_strobe", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("read_strobe_kind", exp_q[0].is_write, 1'b0);
          check("mm_spi_address_rd", mm_spi_address, exp_q[0].addr);
        end
      end
      if (core_grant && !grant_prev && !grant_seen) begin
        grant_seen   = 1'b1;
        pmn_at_grant = pmn_count;
      end
      grant_prev = core_grant;
      if (spi_ack) begin
        ack_count++;
        check("sb_has_op_at_ack", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_op = exp_q.pop_front();
          if (mon_op.is_write) check("write_ack_with_strobe", program_memory_new, 1'b1);
          else                 check("spi_rdata", spi_rdata, mon_op.data);
        end
      end
    end else begin
      grant_prev = 1'b0;
    end
  end

  function automatic logic sig_sel(input int sel);
    case (sel)
      SEL_ACK:     return spi_ack;
      SEL_RMS:     return read_memory_sync;
      SEL_GRANT:   return core_grant;
      SEL_NOGRANT: return !core_grant;
      SEL_IDLE:    return !spi_busy;
      default:     return 1'b0;
    endcase
  endfunction

  // Bounded wait (from a negedge) for a condition; reports the cycle it was seen.
  task automatic wait_for(input string tag, input int sel, input int budget, output int at);
    logic found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < budget; i++) begin
      if (sig_sel(sel)) begin
        found = 1'b1;
        at    = cyc;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_seen"}, found, 1'b1);
  endtask

  task automatic spi_write(input logic [SAW-1:0] a, input logic [MBW-1:0] d);
    spi_write_req = 1'b1;
    spi_address   = a;
    spi_data_in   = d;
    exp_q.push_back('{is_write: 1'b1, addr: a, data: d});
    ref_mem[a] = d;
    @(negedge clk);
    spi_write_req = 1'b0;
  endtask

  task automatic spi_read(input logic [SAW-1:0] a);
    spi_read_req = 1'b1;
    spi_address  = a;
    exp_q.push_back('{is_write: 1'b0, addr: a, data: ref_rd(a)});
    @(negedge clk);
    spi_read_req = 1'b0;
  endtask

  logic [SAW-1:0] tbl_addr [4] = '{14'h0005, 14'h0000, 14'h3FFF, 14'h1234};
  logic [MBW-1:0] tbl_data [4] = '{32'hDEADBEEF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h5A5A_A5A5};

  initial begin
    int t0, at, at2, acks_before;
    spi_write_req = 0; spi_read_req = 0; spi_overrun_clear = 0;
    spi_address = '0; spi_data_in = '0;
    core_req = 0; core_chip_select = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_spi_ack", spi_ack, 0);
    check("rst_spi_busy", spi_busy, 0);
    check("rst_strobes", {program_memory_new, read_memory_sync}, 0);
    check("rst_grant_cs", {core_grant, control_chip_select}, 0);
    check("rst_overrun", spi_overrun, 0);
    check("rst_held_regs", {mm_spi_address, mm_spi_data_in, spi_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write: strobe and ack together, 2 cycles after the request.
    t0 = cyc;
    spi_write(tbl_addr[0], tbl_data[0]);
    check("busy_after_request", spi_busy, 1);
    wait_for("wr1_ack", SEL_ACK, 20, at);
    check("wr1_ack_latency", at - t0, 2);
    @(negedge clk);
    check("wr1_strobe_width", program_memory_new, 0);
    check("wr1_ack_width", spi_ack, 0);
    for (int i = 1; i < 4; i++) begin
      wait_for("tbl_wr_idle", SEL_IDLE, 20, at);
      spi_write(tbl_addr[i], tbl_data[i]);
    end
    wait_for("tbl_wr_ack", SEL_ACK, 20, at);
    @(negedge clk);

    // Read with latency: ack READ_LATENCY+1 cycles after the strobe rises.
    t0 = cyc;
    spi_read(tbl_addr[0]);
    wait_for("rd1_strobe", SEL_RMS, 20, at);
    check("rd1_strobe_latency", at - t0, 2);
    @(negedge clk);
    check("rd1_strobe_width", read_memory_sync, 0);
    wait_for("rd1_ack", SEL_ACK, 20, at2);
    check("rd1_ack_after_strobe", at2 - at, RL + 1);
    repeat (4) @(negedge clk);
    check("rdata_held", spi_rdata, 32'hDEADBEEF);
    for (int i = 1; i < 4; i++) begin
      spi_read(tbl_addr[i]);
      wait_for("tbl_rd_ack", SEL_ACK, 20, at);
      @(negedge clk);
    end

    // Streak limit: core waits behind 4 SPI writes, then gets the memory.
    pmn_count  = 0;
    grant_seen = 1'b0;
    spi_write(14'h0100, 32'h1000_0000);
    core_req = 1'b1;
    for (int k = 1; k < 6; k++) begin
      wait_for("t3_port_free", SEL_IDLE, 64, at);
      spi_write(14'h0100 + 14'(k), 32'h1000_0000 + 32'(k));
    end
    wait_for("t3_last_ack", SEL_ACK, 64, at);
    wait_for("t3_regrant", SEL_GRANT, 20, at);
    core_req = 1'b0;
    wait_for("t3_release", SEL_NOGRANT, 20, at);
    check("t3_spi_ops_before_grant", pmn_at_grant, 4);
    check("t3_total_writes", pmn_count, 6);

    // Core preemption after MAX_CORE_HOLD cycles with an SPI read pending.
    core_req = 1'b1;
    core_chip_select = 1'b1;
    wait_for("t4_grant", SEL_GRANT, 20, at);
    check("t4_cs_when_granted", control_chip_select, 1);
    t0 = cyc;
    spi_read(14'h0103);
    wait_for("t4_preempt", SEL_NOGRANT, 40, at);
    check("t4_preempt_cycles", at - t0, 17);
    check("t4_cs_gated", control_chip_select, 0);
    wait_for("t4_read_ack", SEL_ACK, 20, at);
    wait_for("t4_regrant", SEL_GRANT, 20, at2);
    check("t4_regrant_after_ack", at2 - at, 1);
    core_req = 1'b0;
    core_chip_select = 1'b0;
    wait_for("t4_release", SEL_NOGRANT, 20, at);

    // Overrun: request while busy is dropped; flag sticky until cleared.
    spi_write(14'h0200, 32'h1111_1111);
    spi_write_req = 1'b1; spi_address = 14'h0201; spi_data_in = 32'h2222_2222;
    @(negedge clk);
    spi_write_req = 1'b0;
    check("ovr_set", spi_overrun, 1);
    wait_for("ovr_ack", SEL_ACK, 20, at);
    @(negedge clk);
    spi_read(14'h0201);
    wait_for("ovr_dropped_rd", SEL_ACK, 20, at);
    check("ovr_sticky", spi_overrun, 1);
    @(negedge clk);
    // Simultaneous write + read request: write wins, overrun flagged.
    spi_read_req = 1'b1;
    spi_write(14'h0300, 32'h3333_3333);
    spi_read_req = 1'b0;
    wait_for("both_ack", SEL_ACK, 20, at);
    @(negedge clk);
    spi_overrun_clear = 1'b1;
    @(negedge clk);
    spi_overrun_clear = 1'b0;
    check("ovr_cleared", spi_overrun, 0);
    spi_read(14'h0300);
    wait_for("both_rd_ack", SEL_ACK, 20, at);
    check("both_not_overrun_rd", spi_overrun, 0);
    @(negedge clk);
    // Clear and new overrun in the same cycle: flag stays set.
    spi_write(14'h0400, 32'h4444_4444);
    spi_write_req = 1'b1; spi_overrun_clear = 1'b1;
    @(negedge clk);
    spi_write_req = 1'b0; spi_overrun_clear = 1'b0;
    check("ovr_set_beats_clear", spi_overrun, 1);
    wait_for("ovr2_ack", SEL_ACK, 20, at);
    spi_overrun_clear = 1'b1;
    @(negedge clk);
    spi_overrun_clear = 1'b0;

    // Reset in the middle of a read: no ack, everything back to zero.
    spi_read(14'h0005);
    wait_for("rst_rd_strobe", SEL_RMS, 20, at);
    @(negedge clk);
    acks_before = ack_count;
    rst_n = 1'b0;
    #1;
    check("midrst_busy_ack", {spi_busy, spi_ack}, 0);
    check("midrst_strobes", {program_memory_new, read_memory_sync}, 0);
    check("midrst_held_regs", {mm_spi_address, mm_spi_data_in, spi_rdata}, 0);
    check("midrst_overrun", spi_overrun, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_ack", ack_count, acks_before);
    check("midrst_not_busy", spi_busy, 0);

`ifdef MEM_ARB_STALL_COUNTER_EN
    // Stall counter: core waits behind a read (RL + 3 ungranted cycles).
    spi_overrun_clear = 1'b1;
    @(negedge clk);
    spi_overrun_clear = 1'b0;
    check("stall_cleared", core_stall_cycles, 0);
    spi_read(14'h0005);
    core_req = 1'b1;
    wait_for("stall_grant", SEL_GRANT, 30, at);
    core_req = 1'b0;
    @(negedge clk);
    check("stall_cycles", core_stall_cycles, RL + 3);
    wait_for("stall_release", SEL_NOGRANT, 20, at);
`endif

    repeat (2) @(negedge clk);
    check("strobe_grant_exclusive", excl_viol, 0);
    check("chip_select_gating", cs_viol, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
